// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I instructions into an ALU opcode plus operands and
// buffers the results in a 2-entry in-order FIFO. All outputs come straight
// from the head-entry register, so there is no combinational path from any
// input to any output.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   IN_VALID_i / IN_READY_o     upstream handshake
//   INSTR_i, RS1_DATA_i,
//   RS2_DATA_i, PC_i            instruction word, operands, instruction address
//   OUT_VALID_o / OUT_READY_i   downstream handshake
//   ALU_OP_o, ALU_A_o, ALU_B_o  ALU opcode and operands
//   BR_o, BR_INV_o, ILLEGAL_o   branch, inverted branch, undecodable instruction
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IN_VALID_i,
  output logic        IN_READY_o,
  input  logic [31:0] INSTR_i,
  input  logic [31:0] RS1_DATA_i,
  input  logic [31:0] RS2_DATA_i,
  input  logic [31:0] PC_i,
  output logic        OUT_VALID_o,
  input  logic        OUT_READY_i,
  output logic [3:0]  ALU_OP_o,
  output logic [31:0] ALU_A_o,
  output logic [31:0] ALU_B_o,
  output logic        BR_o,
  output logic        BR_INV_o,
  output logic        ILLEGAL_o
);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_SUM = 4'b0010,
                         OP_EQ  = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101,
                         OP_SRA = 4'b0111, OP_XOR = 4'b1000, OP_SUB = 4'b1010,
                         OP_GE  = 4'b1100, OP_GEU = 4'b1101, OP_SLT = 4'b1110,
                         OP_SLTU = 4'b1111;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_LUI = 7'b0110111,
                         OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        br_inv;
    logic        ill;
  } entry_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_zero, f7_alt;
  logic [31:0] imm_i, imm_s, imm_u;
  entry_t      dec;

  assign opc     = INSTR_i[6:0];
  assign f3      = INSTR_i[14:12];
  assign f7      = INSTR_i[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);
  assign imm_i   = {{20{INSTR_i[31]}}, INSTR_i[31:20]};
  assign imm_s   = {{20{INSTR_i[31]}}, INSTR_i[31:25], INSTR_i[11:7]};
  assign imm_u   = {INSTR_i[31:12], 12'b0};

  always_comb begin
    dec = '0;
    case (opc)
      OPC_OP, OPC_OPIMM: begin
        dec.a = RS1_DATA_i;
        dec.b = (opc == OPC_OP) ? RS2_DATA_i : imm_i;
        case (f3)
          3'b000: begin
            // OP-IMM has no SUBI: funct7 bits are immediate there
            if (opc == OPC_OP) begin
              dec.op  = f7_alt ? OP_SUB : OP_SUM;
              dec.ill = !(f7_zero || f7_alt);
            end else begin
              dec.op = OP_SUM;
            end
          end
          3'b001: begin
            dec.op  = OP_SLL;
            dec.ill = !f7_zero;
          end
          3'b010: begin
            dec.op  = OP_SLT;
            dec.ill = (opc == OPC_OP) && !f7_zero;
          end
          3'b011: begin
            dec.op  = OP_SLTU;
            dec.ill = (opc == OPC_OP) && !f7_zero;
          end
          3'b100: begin
            dec.op  = OP_XOR;
            dec.ill = (opc == OPC_OP) && !f7_zero;
          end
          3'b101: begin
            dec.op  = f7_alt ? OP_SRA : OP_SRL;
            dec.ill = !(f7_zero || f7_alt);
          end
          3'b110: begin
            dec.op  = OP_OR;
            dec.ill = (opc == OPC_OP) && !f7_zero;
          end
          default: begin
            dec.op  = OP_AND;
            dec.ill = (opc == OPC_OP) && !f7_zero;
          end
        endcase
        if (opc == OPC_OPIMM && (f3 == 3'b001 || f3 == 3'b101))
          dec.b = {27'b0, INSTR_i[24:20]};
      end
      OPC_BRANCH: begin
        dec.br = 1'b1;
        dec.a  = RS1_DATA_i;
        dec.b  = RS2_DATA_i;
        case (f3)
          3'b000: dec.op = OP_EQ;
          3'b001: begin
            dec.op     = OP_EQ;
            dec.br_inv = 1'b1;
          end
          3'b100: dec.op = OP_SLT;
          3'b101: dec.op = OP_GE;
          3'b110: dec.op = OP_SLTU;
          3'b111: dec.op = OP_GEU;
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.op = OP_SUM;
        dec.a  = RS1_DATA_i;
        dec.b  = imm_i;
      end
      OPC_STORE: begin
        dec.op = OP_SUM;
        dec.a  = RS1_DATA_i;
        dec.b  = imm_s;
      end
      OPC_LUI: begin
        dec.op = OP_SUM;
        dec.b  = imm_u;
      end
      OPC_AUIPC: begin
        dec.op = OP_SUM;
        dec.a  = PC_i;
        dec.b  = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        dec.op = OP_SUM;
        dec.a  = PC_i;
        dec.b  = 32'd4;
      end
      default: dec.ill = 1'b1;
    endcase
    // Any illegal instruction presents as a clean AND 0,0 with no branch
    if (dec.ill) begin
      dec        = '0;
      dec.ill    = 1'b1;
    end
  end

  // Shift-register FIFO: head_q always drives the outputs, tail_q is the
  // second entry and moves into head on a pop.
  entry_t     head_q, head_d, tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign IN_READY_o  = (count_q != 2'd2);
  assign OUT_VALID_o = (count_q != 2'd0);
  assign push        = IN_VALID_i && IN_READY_o;
  assign pop         = OUT_VALID_o && OUT_READY_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = dec;
        else                 tail_d = dec;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous push/pop only happens with one entry held (push needs
      // count<2, pop needs count>0), so the new entry becomes head directly.
      2'b11: head_d = dec;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign ALU_OP_o  = head_q.op;
  assign ALU_A_o   = head_q.a;
  assign ALU_B_o   = head_q.b;
  assign BR_o      = head_q.br;
  assign BR_INV_o  = head_q.br_inv;
  assign ILLEGAL_o = head_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IN_VALID_i = 1'b0;
  logic        IN_READY_o;
  logic [31:0] INSTR_i = '0, RS1_DATA_i = '0, RS2_DATA_i = '0, PC_i = '0;
  logic        OUT_VALID_o;
  logic        OUT_READY_i = 1'b1;
  logic [3:0]  ALU_OP_o;
  logic [31:0] ALU_A_o, ALU_B_o;
  logic        BR_o, BR_INV_o, ILLEGAL_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .IN_VALID_i(IN_VALID_i), .IN_READY_o(IN_READY_o),
    .INSTR_i(INSTR_i), .RS1_DATA_i(RS1_DATA_i), .RS2_DATA_i(RS2_DATA_i), .PC_i(PC_i),
    .OUT_VALID_o(OUT_VALID_o), .OUT_READY_i(OUT_READY_i),
    .ALU_OP_o(ALU_OP_o), .ALU_A_o(ALU_A_o), .ALU_B_o(ALU_B_o),
    .BR_o(BR_o), .BR_INV_o(BR_INV_o), .ILLEGAL_o(ILLEGAL_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    chk({tag, ".valid"}, {31'b0, OUT_VALID_o}, 32'd1);
    chk({tag, ".op"},    {28'b0, ALU_OP_o}, {28'b0, op});
    chk({tag, ".a"},     ALU_A_o, a);
    chk({tag, ".b"},     ALU_B_o, b);
  endtask

  // Called at a negedge with the FIFO empty and OUT_READY_i=1.
  task automatic issue_one(input string tag, input logic [31:0] instr,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] pc, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic br, input logic inv, input logic ill);
    chk({tag, ".rdy"}, {31'b0, IN_READY_o}, 32'd1);
    IN_VALID_i = 1'b1; INSTR_i = instr; RS1_DATA_i = rs1; RS2_DATA_i = rs2; PC_i = pc;
    @(posedge clk); @(negedge clk);
    IN_VALID_i = 1'b0;
    chk_head(tag, op, a, b);
    chk({tag, ".br"},  {31'b0, BR_o},      {31'b0, br});
    chk({tag, ".inv"}, {31'b0, BR_INV_o},  {31'b0, inv});
    chk({tag, ".ill"}, {31'b0, ILLEGAL_o}, {31'b0, ill});
    @(posedge clk); @(negedge clk);
    chk({tag, ".drain"}, {31'b0, OUT_VALID_o}, 32'd0);
  endtask

  initial begin
    #3;
    chk("rst.valid", {31'b0, OUT_VALID_o}, 32'd0);
    chk("rst.rdy",   {31'b0, IN_READY_o},  32'd1);
    chk("rst.op",    {28'b0, ALU_OP_o},    32'd0);
    chk("rst.a",     ALU_A_o, 32'd0);
    chk("rst.b",     ALU_B_o, 32'd0);
    chk("rst.flags", {29'b0, BR_o, BR_INV_o, ILLEGAL_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    //         tag      instr          rs1   rs2   pc           op       a            b            br    inv   ill
    issue_one("add",   32'h002081B3, 5,    7,    0,           4'b0010, 5,           7,           1'b0, 1'b0, 1'b0);
    issue_one("sub",   32'h402081B3, 5,    7,    0,           4'b1010, 5,           7,           1'b0, 1'b0, 1'b0);
    issue_one("addi",  32'hFFF00093, 9,    1,    0,           4'b0010, 9,           32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    issue_one("srai",  32'h4030D093, 32'h80, 1,  0,           4'b0111, 32'h80,      3,           1'b0, 1'b0, 1'b0);
    issue_one("bne",   32'h00209463, 11,   12,   0,           4'b0011, 11,          12,          1'b1, 1'b1, 1'b0);
    issue_one("bgeu",  32'h0020F463, 3,    4,    0,           4'b1101, 3,           4,           1'b1, 1'b0, 1'b0);
    issue_one("lui",   32'h123452B7, 77,   1,    0,           4'b0010, 0,           32'h12345000, 1'b0, 1'b0, 1'b0);
    issue_one("auipc", 32'h00001097, 77,   1,    32'h400,     4'b0010, 32'h400,     32'h1000,    1'b0, 1'b0, 1'b0);
    issue_one("jal",   32'h0000006F, 77,   1,    32'h80000010, 4'b0010, 32'h80000010, 4,        1'b0, 1'b0, 1'b0);
    issue_one("sw",    32'h0020A423, 32'h100, 1, 0,           4'b0010, 32'h100,     8,           1'b0, 1'b0, 1'b0);
    issue_one("swneg", 32'hFE20AE23, 32'h100, 1, 0,           4'b0010, 32'h100,     32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);
    issue_one("sltu",  32'h0020B1B3, 2,    3,    0,           4'b1111, 2,           3,           1'b0, 1'b0, 1'b0);
    issue_one("mul",   32'h022081B3, 2,    3,    0,           4'b0000, 0,           0,           1'b0, 1'b0, 1'b1);
    issue_one("br010", 32'h0020A463, 2,    3,    0,           4'b0000, 0,           0,           1'b0, 1'b0, 1'b1);
    issue_one("ones",  32'hFFFFFFFF, 2,    3,    5,           4'b0000, 0,           0,           1'b0, 1'b0, 1'b1);

    // Stall: three back-to-back pushes with downstream blocked
    OUT_READY_i = 1'b0;
    IN_VALID_i = 1'b1; INSTR_i = 32'h002081B3; RS1_DATA_i = 5; RS2_DATA_i = 7;
    @(posedge clk); @(negedge clk);
    chk("st1.rdy", {31'b0, IN_READY_o}, 32'd1);
    INSTR_i = 32'h402081B3; RS1_DATA_i = 20; RS2_DATA_i = 3;
    @(posedge clk); @(negedge clk);
    chk("st2.rdy", {31'b0, IN_READY_o}, 32'd0);
    chk_head("st2", 4'b0010, 5, 7);
    INSTR_i = 32'h123452B7; RS1_DATA_i = 99; RS2_DATA_i = 98;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold.rdy", {31'b0, IN_READY_o}, 32'd0);
      chk_head("hold", 4'b0010, 5, 7);
    end
    OUT_READY_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel1.rdy", {31'b0, IN_READY_o}, 32'd1);
    chk_head("rel1", 4'b1010, 20, 3);
    @(posedge clk); @(negedge clk);
    IN_VALID_i = 1'b0;
    chk_head("rel2", 4'b0010, 0, 32'h12345000);
    @(posedge clk); @(negedge clk);
    chk("rel3.valid", {31'b0, OUT_VALID_o}, 32'd0);

    // Async reset with two entries buffered
    OUT_READY_i = 1'b0;
    IN_VALID_i = 1'b1; INSTR_i = 32'h0020B1B3; RS1_DATA_i = 2; RS2_DATA_i = 3;
    @(posedge clk); @(posedge clk); @(negedge clk);
    IN_VALID_i = 1'b0;
    chk("pre.rdy", {31'b0, IN_READY_o}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'b0, OUT_VALID_o}, 32'd0);
    chk("arst.rdy",   {31'b0, IN_READY_o},  32'd1);
    chk("arst.op",    {28'b0, ALU_OP_o},    32'd0);
    chk("arst.a",     ALU_A_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    OUT_READY_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      chk("post.valid", {31'b0, OUT_VALID_o}, 32'd0);
    end
    issue_one("after", 32'h00209463, 6, 6, 0, 4'b0011, 6, 6, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
